// File: rtl/gelato_arb_pkg.sv
// Shared types and helpers for the gelato FIFO write-port arbiter.
// Provides the arbiter state encoding and a wrap-around index increment.
package gelato_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Returns idx+1, wrapping to 0 at n.
  function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/gelato_rr_picker.sv
// Combinational round-robin picker: finds the first set request at or after ptr, wrapping.
// Reusable by any arbiter that keeps its own rotating pointer.
module gelato_rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;

  // The lower copy only sees requests at or above ptr; the upper copy supplies the wrap.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    dbl    = {req, req};
    mask   = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 2 * N; i++) begin
      mask[i] = (i >= N) || (i >= int'(ptr));
    end
    masked = dbl & mask;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && masked[i]) begin
        found = 1'b1;
        idx   = IDW'((i >= N) ? i - N : i);
      end
    end
  end

endmodule

// File: rtl/gelato_fifo_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// holding the port for bursts of up to MAX_BURST beats so bursts stay contiguous.
module gelato_fifo_arbiter
  import gelato_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  MAX_BURST = 4,
  parameter type T         = logic,
  parameter int  IDW       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  T                   req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_last,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  output T                   out_data,
  input  logic               out_ready,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  arb_state_e     state;
  arb_state_e     state_nxt;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  beat_cnt;

  logic [IDW-1:0] winner;
  logic [IDW-1:0] g;
  logic           found;
  logic           beat;
  logic           terminal;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return IDW'(mod_inc(32'(i), NUM_REQ));
  endfunction

  gelato_rr_picker #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (winner)
  );

  assign g        = (state == LOCKED) ? owner : winner;
  assign beat     = out_valid && out_ready;
  assign terminal = beat && (req_last[g] || (beat_cnt == LAST_CNT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: in IDLE any presented beat that does not end the grant locks it,
  // including a stall, so the grant cannot move while data is on the port.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found && !terminal) state_nxt = LOCKED;
      LOCKED:  if (terminal)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, round-robin pointer and burst beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (terminal) begin
            rr_ptr <= next_idx(winner);
          end else if (found) begin
            owner <= winner;
            if (beat) beat_cnt <= CW'(1);
          end
        end
        LOCKED: begin
          if (terminal) begin
            rr_ptr   <= next_idx(owner);
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: the data path is purely combinational; control outputs are forced low during reset.
  always_comb begin
    out_valid = 1'b0;
    req_ready = '0;
    grant_id  = '0;
    busy      = 1'b0;
    out_data  = req_data[g];
    if (!rst) begin
      grant_id = g;
      busy     = (state == LOCKED);
      if (state == LOCKED) begin
        out_valid        = req_valid[owner];
        req_ready[owner] = out_ready;
      end else if (found) begin
        out_valid         = 1'b1;
        req_ready[winner] = out_ready;
      end
    end
  end

endmodule

// File: tb/tb_gelato_fifo_arbiter.sv
// Self-checking bench for gelato_fifo_arbiter: per-cycle vector table plus a scoreboard
// of beats expected to reach the FIFO, with hand-written reset sequences.
module tb_gelato_fifo_arbiter;

  localparam int N = 4;
  typedef logic [7:0] data_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic       ov;
    logic [1:0] gid;
    logic       busy;
    logic [3:0] rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  data_t      req_data [N];
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic       out_valid;
  data_t      out_data;
  logic       out_ready;
  logic [1:0] grant_id;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  vec_t       tab [$];
  data_t      exp_q [$];
  logic [3:0] seq [N];

  always #5 clk = ~clk;

  gelato_fifo_arbiter #(
    .NUM_REQ   (N),
    .MAX_BURST (4),
    .T         (data_t)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic o,
                              input logic ov, input logic [1:0] g, input logic b,
                              input logic [3:0] r);
    vec_t t;
    t.valid = v; t.last = l; t.ordy = o; t.ov = ov; t.gid = g; t.busy = b; t.rdy = r;
    return t;
  endfunction

  function automatic data_t data_of(input int i);
    return {4'(i), seq[i]};
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i] = data_of(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " req_ready"}, 32'(req_ready), 32'd0);
    check({tag, " grant_id"},  32'(grant_id),  32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
  endtask

  task automatic apply(input vec_t v, input int k);
    data_t exp_d;
    @(negedge clk);
    req_valid = v.valid;
    req_last  = v.last;
    out_ready = v.ordy;
    drive_data();
    exp_d = data_of(int'(v.gid));
    if (v.ov && v.ordy) exp_q.push_back(exp_d);
    #1;
    check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(v.ov));
    check($sformatf("v%0d grant_id", k),  32'(grant_id),  32'(v.gid));
    check($sformatf("v%0d busy", k),      32'(busy),      32'(v.busy));
    check($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(v.rdy));
    if (v.ov) check($sformatf("v%0d out_data", k), 32'(out_data), 32'(exp_d));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d fifo_beat: got beat %0h expected no beat", k, out_data);
      end else begin
        check($sformatf("v%0d fifo_beat", k), 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    if (v.ov && v.ordy) seq[v.gid] = seq[v.gid] + 4'd1;
  endtask

  task automatic run(input int from, input int to);
    for (int k = from; k < to; k++) apply(tab[k], k);
  endtask

  initial begin
    // Single requester 2: 3-beat burst, then a probe that shows rr_ptr moved to 3.
    tab.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100));  // 0
    tab.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100));  // 1
    tab.push_back(mk(4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100));  // 2
    tab.push_back(mk(4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000));  // 3
    // Wrap-around: park pointer at 3, then alternate between 3 and 0.
    tab.push_back(mk(4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100));  // 4
    tab.push_back(mk(4'b1001, 4'b1001, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000));  // 5
    tab.push_back(mk(4'b1001, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001));  // 6
    tab.push_back(mk(4'b1001, 4'b1001, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000));  // 7
    tab.push_back(mk(4'b1001, 4'b1001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001));  // 8
    // Stall: requester 1 presents under full FIFO, 0 joins mid-stall.
    tab.push_back(mk(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000));  // 9
    tab.push_back(mk(4'b0011, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000));  // 10
    tab.push_back(mk(4'b0011, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000));  // 11
    tab.push_back(mk(4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010));  // 12
    tab.push_back(mk(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001));  // 13
    // First beat of a burst from 3 before the mid-burst reset.
    tab.push_back(mk(4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1000));  // 14
    // After reset: 1 wins over 3; then owner 2 drops valid for two cycles.
    tab.push_back(mk(4'b1010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0010));  // 15
    tab.push_back(mk(4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010));  // 16
    tab.push_back(mk(4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0100));  // 17
    tab.push_back(mk(4'b0001, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0100));  // 18
    tab.push_back(mk(4'b0001, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0100));  // 19
    tab.push_back(mk(4'b0101, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100));  // 20
    tab.push_back(mk(4'b0101, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100));  // 21
    tab.push_back(mk(4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001));  // 22
    // Fairness: all valid, never last, bursts capped at 4 beats in order 0,1,2,3,0.
    for (int k = 0; k < 20; k++) begin
      int g;
      g = (k / 4) % 4;
      tab.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b1, 2'(g), 1'((k % 4) != 0),
                       4'b0001 << g));
    end

    for (int i = 0; i < N; i++) seq[i] = 4'd0;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b0000;
    out_ready = 1'b1;
    drive_data();
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0000;

    run(0, 15);

    // Reset in the middle of beat 2 of requester 3's burst.
    @(negedge clk);
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    out_ready = 1'b1;
    drive_data();
    #1;
    check("pre_rst busy", 32'(busy), 32'd1);
    check("pre_rst out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst_hold");
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0000;

    run(15, 23);

    @(negedge clk);
    req_valid = 4'b0000;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    run(23, 43);

    check("fifo_leftover", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gelato_fifo_arbiter.md
# gelato_fifo_arbiter

- Round-robin arbiter that shares one FIFO write port (valid/ready/data) among `NUM_REQ` requesters.
- A requester can hold the port for a burst of up to `MAX_BURST` beats, so its beats enter the FIFO contiguously.
- Sits in front of the shared FIFO's `din`/`din_valid`/`din_ready` side; the FIFO's read side is untouched.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `MAX_BURST`, 4, max beats per grant (≥1)
- `T`, logic, payload type (matches FIFO `T`)
- `IDW`, $clog2(NUM_REQ), derived; width of requester index

Ports:
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester valid
- `req_data`  in  T[NUM_REQ]  per-requester payload
- `req_last`  in  NUM_REQ  beat ends requester's burst
- `req_ready`  out  NUM_REQ  per-requester ready (one-hot or zero)
- `out_valid`  out  1  to FIFO `din_valid`
- `out_data`  out  T  to FIFO `din`
- `out_ready`  in  1  from FIFO `din_ready`
- `grant_id`  out  IDW  index currently forwarded
- `busy`  out  1  high in LOCKED

## Operation
- State: `IDLE`, `LOCKED`. Registers: `state`, `owner` (IDW), `rr_ptr` (IDW), `beat_cnt` ($clog2(MAX_BURST+1) bits).
- Winner selection in IDLE: first `i` with `req_valid[i]`, scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ` (wrap at `NUM_REQ-1`→0).
- Forwarded index `g`:
  - IDLE: `g` = winner.
  - LOCKED: `g` = `owner`.
  - `grant_id = g`.
- Forwarding:
  - `out_valid = req_valid[g]` (in IDLE, = any `req_valid`).
  - `out_data = req_data[g]`.
  - `req_ready[g] = out_ready` in IDLE when a winner exists, and always in LOCKED.
  - All other `req_ready` bits are 0.
- Beat and terminal beat:
  - Beat = `out_valid && out_ready`.
  - Terminal beat = beat with `req_last[g]`, or beat where `beat_cnt == MAX_BURST-1`.
- IDLE transitions:
  - Terminal beat: stay IDLE; `rr_ptr <= winner+1` (mod NUM_REQ).
  - Non-terminal beat: go LOCKED; `owner <= winner`; `beat_cnt <= 1`.
  - `out_valid && !out_ready` (stall): go LOCKED; `owner <= winner`; `beat_cnt` stays 0. The grant must not move while data is presented.
  - No `req_valid`: stay IDLE; nothing changes.
- LOCKED transitions:
  - Terminal beat: go IDLE; `rr_ptr <= owner+1`; `beat_cnt <= 0`.
  - Non-terminal beat: `beat_cnt++`.
  - Otherwise hold.
  - Owner dropping `req_valid` while LOCKED is a protocol violation. The arbiter stays LOCKED with `out_valid=0` and does not re-arbitrate.
- `MAX_BURST=1`: every beat is terminal. LOCKED is entered only on stalls.
- Other requesters' `req_valid`/`req_last` never affect LOCKED.

## Timing
- Zero-latency combinational paths:
  - `req_valid`/`req_data` → `out_valid`/`out_data`.
  - `out_ready` → `req_ready`.
- No registers on the data path.
- State, `owner`, `rr_ptr` and `beat_cnt` update on the `clk` rising edge. The grant change takes effect the cycle after a terminal beat.
- Fairness: with all requesters continuously valid and `out_ready=1`, each holds the port for at most `MAX_BURST` consecutive beats. Service order is 0,1,…,NUM_REQ-1,0…
- Reset (`rst=1`, asynchronous, takes effect immediately, also mid-burst):
  - Registers: `state=IDLE`, `owner=0`, `rr_ptr=0`, `beat_cnt=0`.
  - Outputs forced while `rst=1`: `out_valid=0`, `req_ready=0`, `grant_id=0`, `busy=0`.
  - A partial burst is abandoned. The first grant after reset release goes to the lowest valid index.
- FIFO full (`out_ready=0`) at any point: hold the current state, no beat counted, `req_ready` all 0.

## Structure
- Package `gelato_arb_pkg`: `typedef enum logic {IDLE, LOCKED} arb_state_e`; helper `function` for modular increment of the index.
- Sub-module `gelato_rr_picker` (combinational):
  - Inputs: `req` vector, `ptr`.
  - Outputs: `found`, `idx`.
  - Implemented as a double-width masked priority scan.
  - Reusable by other arbiters in the design.
- Top-level: FSM, counters, output muxing.

## Test plan
- Single requester 2, 3-beat burst with `req_last` on beat 3, `out_ready=1` → `req_ready[2]` high three cycles, `busy` high cycles 2–3, `rr_ptr=3` after.
- All four valid, never `last`, `MAX_BURST=4`, `out_ready=1` → grant sequence 0×4,1×4,2×4,3×4,0×4; FIFO receives contiguous bursts.
- Requester 1 presents while `out_ready=0` for 3 cycles, requester 0 raises valid mid-stall → `grant_id` stays 1 and `out_data` stays stable; beat accepted on ready; 0 is served next.
- `rst` pulsed during beat 2 of a 4-beat burst from requester 3 → outputs 0 immediately; after release, valid on 1 and 3 → requester 1 granted first.
- `rr_ptr=3`, only requesters 0 and 3 valid, single-beat (`last`) each → order 3,0,3,0 (wrap-around).
- Owner 2 drops `req_valid` mid-burst for 2 cycles while 0 is valid → `busy=1`, `out_valid=0`, no grant to 0; burst resumes when 2 reasserts.
